// File: rtl/cache_miss_ctrl.sv
// Miss-sequencing controller for the set-associative cache: tag lookup, dirty
// victim write-back, beat-wise line refill, tag/LRU update and CPU response.
module cache_miss_ctrl #(
  parameter int idx_wid    = 10,
  parameter int tag_wid    = 20,
  parameter int word_wid   = 64,
  parameter int line_words = 4,
  localparam int off_wid   = $clog2(line_words),
  localparam int addr_wid  = tag_wid + idx_wid + off_wid
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  // CPU request port
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic                           req_we_i,
  input  logic [tag_wid-1:0]             req_tag_i,
  input  logic [idx_wid-1:0]             req_idx_i,
  input  logic [off_wid-1:0]             req_off_i,
  input  logic [word_wid-1:0]            req_wdata_i,
  output logic                           resp_valid_o,
  output logic [word_wid-1:0]            resp_data_o,
  // tag/data arrays
  output logic                           lkp_en_o,
  output logic [idx_wid-1:0]             lkp_idx_o,
  input  logic                           hit_i,
  input  logic                           dirty_i,
  input  logic [tag_wid-1:0]             victim_tag_i,
  input  logic [line_words*word_wid-1:0] line_i,
  output logic                           arr_we_o,
  output logic [off_wid-1:0]             arr_off_o,
  output logic [word_wid-1:0]            arr_wdata_o,
  output logic                           tag_we_o,
  // LRU tracker
  output logic                           lru_update_o,
  output logic [idx_wid-1:0]             lru_idx_o,
  // memory bus
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [addr_wid-1:0]            mem_addr_o,
  output logic [word_wid-1:0]            mem_wdata_o,
  input  logic                           mem_gnt_i,
  input  logic                           mem_rvalid_i,
  input  logic [word_wid-1:0]            mem_rdata_i,
  // statistics and debug
  output logic [31:0]                    hit_cnt_o,
  output logic [31:0]                    miss_cnt_o,
  output logic [2:0]                     state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_WB       = 3'd2,
    S_FILL_REQ = 3'd3,
    S_FILL     = 3'd4,
    S_UPDATE   = 3'd5,
    S_RESP     = 3'd6
  } state_t;

  localparam logic [off_wid-1:0] last_beat = off_wid'(line_words - 1);

  state_t               state_q, state_d;
  logic                 we_q;
  logic [tag_wid-1:0]   tag_q;
  logic [idx_wid-1:0]   idx_q;
  logic [off_wid-1:0]   off_q;
  logic [word_wid-1:0]  wdata_q;
  logic [tag_wid-1:0]   victim_q;
  logic [word_wid-1:0]  line_q [line_words];
  logic [off_wid-1:0]   beat_q;
  logic [31:0]          hit_cnt_q;
  logic [31:0]          miss_cnt_q;

  // Handshakes: a CPU request transfers on a rising edge where req_valid_i and
  // req_ready_o are both high; a memory beat transfers on an edge where
  // mem_req_o and mem_gnt_i are both high; read beats arrive with mem_rvalid_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (req_valid_i) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (hit_i)        state_d = S_RESP;
        else if (dirty_i) state_d = S_WB;
        else              state_d = S_FILL_REQ;
      end
      S_WB:       if (mem_gnt_i && beat_q == last_beat) state_d = S_FILL_REQ;
      S_FILL_REQ: if (mem_gnt_i) state_d = S_FILL;
      S_FILL:     if (mem_rvalid_i && beat_q == last_beat) state_d = S_UPDATE;
      S_UPDATE:   state_d = S_RESP;
      S_RESP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Memory-side outputs depend only on flops, so they hold steady while a
  // grant is outstanding.
  always_comb begin
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_data_o  = '0;
    lkp_en_o     = 1'b0;
    lkp_idx_o    = '0;
    arr_we_o     = 1'b0;
    arr_off_o    = '0;
    arr_wdata_o  = '0;
    tag_we_o     = 1'b0;
    lru_update_o = 1'b0;
    lru_idx_o    = '0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          lkp_en_o  = 1'b1;
          lkp_idx_o = req_idx_i;
        end
      end
      S_WB: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {victim_q, idx_q, beat_q};
        mem_wdata_o = line_q[beat_q];
      end
      S_FILL_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {tag_q, idx_q, {off_wid{1'b0}}};
      end
      S_FILL: begin
        if (mem_rvalid_i) begin
          arr_we_o    = 1'b1;
          arr_off_o   = beat_q;
          arr_wdata_o = mem_rdata_i;
        end
      end
      S_UPDATE: tag_we_o = 1'b1;
      S_RESP: begin
        resp_valid_o = 1'b1;
        lru_update_o = 1'b1;
        lru_idx_o    = idx_q;
        if (we_q) begin
          arr_we_o    = 1'b1;
          arr_off_o   = off_q;
          arr_wdata_o = wdata_q;
        end else begin
          resp_data_o = line_q[off_q];
        end
      end
      default: ;
    endcase
  end

  // Request capture, victim/line snapshot and beat counting.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q     <= 1'b0;
      tag_q    <= '0;
      idx_q    <= '0;
      off_q    <= '0;
      wdata_q  <= '0;
      victim_q <= '0;
      beat_q   <= '0;
      for (int i = 0; i < line_words; i++) line_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            we_q    <= req_we_i;
            tag_q   <= req_tag_i;
            idx_q   <= req_idx_i;
            off_q   <= req_off_i;
            wdata_q <= req_wdata_i;
          end
        end
        S_LOOKUP: begin
          victim_q <= victim_tag_i;
          beat_q   <= '0;
          for (int i = 0; i < line_words; i++) line_q[i] <= line_i[i*word_wid +: word_wid];
        end
        S_WB: if (mem_gnt_i) beat_q <= beat_q + off_wid'(1);
        S_FILL: begin
          if (mem_rvalid_i) begin
            line_q[beat_q] <= mem_rdata_i;
            beat_q         <= beat_q + off_wid'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating hit/miss statistics.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == S_LOOKUP) begin
      if (hit_i) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Scoreboard bench for cache_miss_ctrl: directed requests push expected
// lookups, memory beats, array writes and responses; a monitor pops and compares.
module tb_cache_miss_ctrl;
  localparam int IDX = 10;
  localparam int TAG = 20;
  localparam int WW  = 64;
  localparam int LW  = 4;
  localparam int OFF = 2;
  localparam int AW  = TAG + IDX + OFF;

  logic              clk, rst_i;
  logic              req_valid_i, req_ready_o, req_we_i;
  logic [TAG-1:0]    req_tag_i;
  logic [IDX-1:0]    req_idx_i;
  logic [OFF-1:0]    req_off_i;
  logic [WW-1:0]     req_wdata_i;
  logic              resp_valid_o;
  logic [WW-1:0]     resp_data_o;
  logic              lkp_en_o;
  logic [IDX-1:0]    lkp_idx_o;
  logic              hit_i, dirty_i;
  logic [TAG-1:0]    victim_tag_i;
  logic [LW*WW-1:0]  line_i;
  logic              arr_we_o;
  logic [OFF-1:0]    arr_off_o;
  logic [WW-1:0]     arr_wdata_o;
  logic              tag_we_o, lru_update_o;
  logic [IDX-1:0]    lru_idx_o;
  logic              mem_req_o, mem_we_o;
  logic [AW-1:0]     mem_addr_o;
  logic [WW-1:0]     mem_wdata_o;
  logic              mem_gnt_i, mem_rvalid_i;
  logic [WW-1:0]     mem_rdata_i;
  logic [31:0]       hit_cnt_o, miss_cnt_o;
  logic [2:0]        state_o;

  cache_miss_ctrl #(.idx_wid(IDX), .tag_wid(TAG), .word_wid(WW), .line_words(LW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_tag_i(req_tag_i), .req_idx_i(req_idx_i), .req_off_i(req_off_i),
    .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
    .lkp_en_o(lkp_en_o), .lkp_idx_o(lkp_idx_o), .hit_i(hit_i), .dirty_i(dirty_i),
    .victim_tag_i(victim_tag_i), .line_i(line_i), .arr_we_o(arr_we_o),
    .arr_off_o(arr_off_o), .arr_wdata_o(arr_wdata_o), .tag_we_o(tag_we_o),
    .lru_update_o(lru_update_o), .lru_idx_o(lru_idx_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o), .state_o(state_o)
  );

  // scoreboard state
  logic [IDX+WW-1:0] exp_q[$];       // {lru_idx, resp_data}
  logic [AW+WW:0]    exp_mem_q[$];   // {we, addr, wdata}
  logic [OFF+WW-1:0] exp_arr_q[$];   // {off, wdata}
  logic [IDX-1:0]    exp_lkp_q[$];
  logic [WW-1:0]     rd_q[$];
  int errors = 0;
  int checks = 0;
  int resp_seen = 0;
  int tag_writes = 0;
  int gnt_delay = 0;
  int wait_cnt = 0;
  int beats_left = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with no expectation queued", name);
  endtask

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory model: grants after gnt_delay wait cycles, returns queued read words
  initial begin
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      if (mem_req_o) begin
        if (wait_cnt >= gnt_delay) begin
          mem_gnt_i = 1'b1;
          wait_cnt  = 0;
          if (!mem_we_o) beats_left = LW;
        end else begin
          wait_cnt++;
        end
      end else if (beats_left > 0 && rd_q.size() > 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rd_q.pop_front();
        beats_left--;
      end
    end
  end

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        if (lkp_en_o) begin
          if (exp_lkp_q.size() == 0) unexpected("lkp");
          else check("lkp_idx", 128'(lkp_idx_o), 128'(exp_lkp_q.pop_front()));
        end
        if (mem_req_o && mem_gnt_i) begin
          if (exp_mem_q.size() == 0) unexpected("mem_beat");
          else check("mem_beat", 128'({mem_we_o, mem_addr_o, mem_we_o ? mem_wdata_o : 64'd0}),
                     128'(exp_mem_q.pop_front()));
        end
        if (arr_we_o) begin
          if (exp_arr_q.size() == 0) unexpected("arr_write");
          else check("arr_write", 128'({arr_off_o, arr_wdata_o}), 128'(exp_arr_q.pop_front()));
        end
        if (tag_we_o) tag_writes++;
        if (resp_valid_o) begin
          resp_seen++;
          check("lru_update", 128'(lru_update_o), 128'(1));
          if (exp_q.size() == 0) unexpected("resp");
          else check("resp", 128'({lru_idx_o, resp_data_o}), 128'(exp_q.pop_front()));
        end
      end
    end
  end

  // driver tasks
  task automatic send_req(input logic we, input logic [TAG-1:0] tag, input logic [IDX-1:0] idx,
                          input logic [OFF-1:0] off, input logic [WW-1:0] wdata);
    bit ok = 0;
    @(posedge clk); #1;
    req_we_i = we; req_tag_i = tag; req_idx_i = idx; req_off_i = off; req_wdata_i = wdata;
    req_valid_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready_o) begin ok = 1; break; end
    end
    if (!ok) unexpected("accept_timeout");
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_resp(input int n);
    for (int i = 0; i < 300 && resp_seen < n; i++) @(negedge clk);
    if (resp_seen < n) unexpected("resp_timeout");
  endtask

  // stimulus
  initial begin
    bit found;
    rst_i = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_tag_i = '0; req_idx_i = '0;
    req_off_i = '0; req_wdata_i = '0;
    hit_i = 1'b0; dirty_i = 1'b0; victim_tag_i = '0; line_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 128'(req_ready_o), 128'(1));
    rst_i = 1'b0;
    @(negedge clk);
    check("idle_ready", 128'(req_ready_o), 128'(1));
    check("idle_hit_cnt", 128'(hit_cnt_o), 128'(0));
    check("idle_miss_cnt", 128'(miss_cnt_o), 128'(0));

    // read hit: idx 5, off 2 -> 30
    hit_i = 1'b1; dirty_i = 1'b0; victim_tag_i = 20'h0;
    line_i = {64'd40, 64'd30, 64'd20, 64'd10};
    exp_lkp_q.push_back(10'd5);
    exp_q.push_back({10'd5, 64'd30});
    send_req(1'b0, 20'h11, 10'd5, 2'd2, 64'd0);
    @(negedge clk);
    check("hit_lat_c1", 128'(resp_valid_o), 128'(0));
    @(negedge clk);
    check("hit_lat_c2", 128'(resp_valid_o), 128'(1));
    @(negedge clk);
    check("hit_ready_c3", 128'(req_ready_o), 128'(1));
    check("hit_cnt_1", 128'(hit_cnt_o), 128'(1));
    check("miss_cnt_0", 128'(miss_cnt_o), 128'(0));

    // clean read miss: tag 3, idx 7, off 1, grant after 3 cycles
    hit_i = 1'b0; dirty_i = 1'b0; victim_tag_i = 20'h77;
    line_i = {64'hEE, 64'hEE, 64'hEE, 64'hEE};
    gnt_delay = 3;
    for (int k = 0; k < LW; k++) rd_q.push_back(64'hA + 64'(k));
    exp_lkp_q.push_back(10'd7);
    exp_mem_q.push_back({1'b0, 20'h3, 10'd7, 2'd0, 64'd0});
    for (int k = 0; k < LW; k++) exp_arr_q.push_back({2'(k), 64'hA + 64'(k)});
    exp_q.push_back({10'd7, 64'hB});
    send_req(1'b0, 20'h3, 10'd7, 2'd1, 64'd0);
    wait_resp(2);
    check("clean_tag_we", 128'(tag_writes), 128'(1));
    check("clean_miss_cnt", 128'(miss_cnt_o), 128'(1));

    // dirty write miss: victim 9, 2-cycle grant stalls, write 0x55 at off 3
    hit_i = 1'b0; dirty_i = 1'b1; victim_tag_i = 20'h9;
    line_i = {64'h103, 64'h102, 64'h101, 64'h100};
    gnt_delay = 2;
    for (int k = 0; k < LW; k++) rd_q.push_back(64'h20 + 64'(k));
    exp_lkp_q.push_back(10'h12);
    for (int k = 0; k < LW; k++) exp_mem_q.push_back({1'b1, 20'h9, 10'h12, 2'(k), 64'h100 + 64'(k)});
    exp_mem_q.push_back({1'b0, 20'h4, 10'h12, 2'd0, 64'd0});
    for (int k = 0; k < LW; k++) exp_arr_q.push_back({2'(k), 64'h20 + 64'(k)});
    exp_arr_q.push_back({2'd3, 64'h55});
    exp_q.push_back({10'h12, 64'd0});
    send_req(1'b1, 20'h4, 10'h12, 2'd3, 64'h55);
    wait_resp(3);
    check("dirty_tag_we", 128'(tag_writes), 128'(2));
    check("dirty_miss_cnt", 128'(miss_cnt_o), 128'(2));

    // back-pressure: valid held through a miss, second request taken once
    hit_i = 1'b0; dirty_i = 1'b0; gnt_delay = 0;
    for (int k = 0; k < LW; k++) rd_q.push_back(64'h1000 + 64'(k));
    for (int k = 0; k < LW; k++) rd_q.push_back(64'h2000 + 64'(k));
    exp_lkp_q.push_back(10'h20);
    exp_lkp_q.push_back(10'h21);
    exp_mem_q.push_back({1'b0, 20'h1, 10'h20, 2'd0, 64'd0});
    exp_mem_q.push_back({1'b0, 20'h2, 10'h21, 2'd0, 64'd0});
    for (int k = 0; k < LW; k++) exp_arr_q.push_back({2'(k), 64'h1000 + 64'(k)});
    for (int k = 0; k < LW; k++) exp_arr_q.push_back({2'(k), 64'h2000 + 64'(k)});
    exp_q.push_back({10'h20, 64'h1000});
    exp_q.push_back({10'h21, 64'h2003});
    @(posedge clk); #1;
    req_we_i = 1'b0; req_tag_i = 20'h1; req_idx_i = 10'h20; req_off_i = 2'd0; req_valid_i = 1'b1;
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready_o) begin found = 1; break; end
    end
    if (!found) unexpected("bp_accept_a");
    @(posedge clk); #1;
    req_tag_i = 20'h2; req_idx_i = 10'h21; req_off_i = 2'd3;
    @(negedge clk);
    check("bp_ready_busy", 128'(req_ready_o), 128'(0));
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready_o) begin found = 1; break; end
    end
    if (!found) unexpected("bp_accept_b");
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    wait_resp(5);
    check("bp_miss_cnt", 128'(miss_cnt_o), 128'(4));

    // reset during fill beat 2; the pending fourth beat arrives late
    hit_i = 1'b0; dirty_i = 1'b0; gnt_delay = 0;
    for (int k = 0; k < LW; k++) rd_q.push_back(64'h300 + 64'(k));
    exp_lkp_q.push_back(10'h33);
    exp_mem_q.push_back({1'b0, 20'h5, 10'h33, 2'd0, 64'd0});
    for (int k = 0; k < 3; k++) exp_arr_q.push_back({2'(k), 64'h300 + 64'(k)});
    send_req(1'b0, 20'h5, 10'h33, 2'd0, 64'd0);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (arr_we_o && arr_off_o == 2'd2) begin found = 1; break; end
    end
    if (!found) unexpected("fill_beat2_timeout");
    #2 rst_i = 1'b1;
    #1;
    check("rst_async_ready", 128'(req_ready_o), 128'(1));
    check("rst_async_outs", 128'(|{resp_valid_o, resp_data_o, lkp_en_o, lkp_idx_o, arr_we_o,
          arr_off_o, arr_wdata_o, tag_we_o, lru_update_o, lru_idx_o, mem_req_o, mem_we_o,
          mem_addr_o, mem_wdata_o, state_o}), 128'(0));
    check("rst_async_hit_cnt", 128'(hit_cnt_o), 128'(0));
    check("rst_async_miss_cnt", 128'(miss_cnt_o), 128'(0));
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_quiet", 128'(|{mem_req_o, arr_we_o, tag_we_o, resp_valid_o}), 128'(0));
    end
    check("late_rvalid_sent", 128'(beats_left), 128'(0));

    // saturation: preload hit counter, one more hit must not wrap
    force dut.hit_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.hit_cnt_q;
    @(negedge clk);
    check("sat_preload", 128'(hit_cnt_o), 128'(32'hFFFF_FFFF));
    hit_i = 1'b1; dirty_i = 1'b0;
    line_i = {64'h0, 64'h0, 64'h0, 64'h5A};
    exp_lkp_q.push_back(10'd3);
    exp_q.push_back({10'd3, 64'h5A});
    send_req(1'b0, 20'h8, 10'd3, 2'd0, 64'd0);
    wait_resp(6);
    @(negedge clk);
    check("hit_cnt_sat", 128'(hit_cnt_o), 128'(32'hFFFF_FFFF));
    check("sat_miss_cnt", 128'(miss_cnt_o), 128'(0));

    // final report
    repeat (3) @(negedge clk);
    check("tag_writes_total", 128'(tag_writes), 128'(4));
    check("resp_q_empty", 128'(exp_q.size()), 128'(0));
    check("mem_q_empty", 128'(exp_mem_q.size()), 128'(0));
    check("arr_q_empty", 128'(exp_arr_q.size()), 128'(0));
    check("lkp_q_empty", 128'(exp_lkp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    checks++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
